// File: rtl/down_counter_pkg.sv
// Shared definitions for the down_counter slice: FSM state codes and parameter defaults.
package down_counter_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_MAX_VAL = 255;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/down_counter_sub_cell.sv
// One bit of the ripple-borrow decrement chain.
module down_counter_sub_cell (
  input  logic q,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = q ^ bin;
  assign bout = ~q & bin;

endmodule

// File: rtl/down_counter.sv
// Loadable, pausable down-counter with start/done handshake and borrow tick.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned MAX_VAL     = DEF_MAX_VAL,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             pause,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  logic [STATE_W-1:0] state, state_nx;
  logic [WIDTH-1:0]   reload, reload_nx, count_nx;
  logic               busy_nx, done_nx, tick_nx;

  logic [WIDTH-1:0]   diff;
  logic [WIDTH:0]     borrow;
  logic [WIDTH-1:0]   load_sat;
  logic               cnt_zero, cnt_one;

  // count-1 via borrow chain; the final borrow-out is set only when count is zero
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_borrow
    down_counter_sub_cell u_cell (
      .q    (count[i]),
      .bin  (borrow[i]),
      .d    (diff[i]),
      .bout (borrow[i+1])
    );
  end

  assign cnt_zero = borrow[WIDTH];
  assign cnt_one  = (count == WIDTH'(1));
  assign load_sat = (load_val > WIDTH'(MAX_VAL)) ? WIDTH'(MAX_VAL) : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      reload <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tick   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      reload <= reload_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      tick   <= tick_nx;
    end
  end

  // Next state with priority abort > load > start > pause > en
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload;
    tick_nx   = 1'b0;

    if (abort) begin
      state_nx = ST_IDLE;
      count_nx = '0;
    end else if (load && (state == ST_IDLE || state == ST_DONE)) begin
      state_nx  = ST_IDLE;
      count_nx  = load_sat;
      reload_nx = load_sat;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nx = cnt_zero ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_nx = ST_PAUSE;
          end else if (en && !cnt_zero) begin
            if (cnt_one) begin
              tick_nx = 1'b1;
              if (AUTO_RELOAD) begin
                count_nx = reload;
              end else begin
                count_nx = diff;
                state_nx = ST_DONE;
              end
            end else begin
              count_nx = diff;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) state_nx = ST_RUN;
        end
        ST_DONE: begin
          if (ack) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end

    busy_nx = (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
    done_nx = (state_nx == ST_DONE);
  end

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: one-shot and auto-reload instances share stimulus.
module tb_down_counter;

  localparam int MAXV = 200;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct {
    int st;
    int cnt;
    int rld;
  } mdl_t;

  typedef struct packed {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0, load = 1'b0, start = 1'b0, en = 1'b0, pause = 1'b0, ack = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] count0, count1;
  logic       busy0, done0, tick0, busy1, done1, tick1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  mdl_t m0 = '{M_IDLE, 0, 0};
  mdl_t m1 = '{M_IDLE, 0, 0};

  always #5 clk = ~clk;

  down_counter #(.WIDTH(8), .MAX_VAL(MAXV), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .load(load), .load_val(load_val),
    .start(start), .en(en), .pause(pause), .ack(ack),
    .count(count0), .busy(busy0), .done(done0), .tick(tick0)
  );

  down_counter #(.WIDTH(8), .MAX_VAL(MAXV), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .load(load), .load_val(load_val),
    .start(start), .en(en), .pause(pause), .ack(ack),
    .count(count1), .busy(busy1), .done(done1), .tick(tick1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: one controller cycle of the counter's rules
  function automatic mdl_t nxt(input mdl_t m, input bit ar, input bit a, input bit l,
                               input bit s, input bit e, input bit p, input bit k,
                               input int lv, output bit tk);
    mdl_t r = m;
    tk = 1'b0;
    if (a) begin
      r.st = M_IDLE;
      r.cnt = 0;
    end else if (l && (m.st == M_IDLE || m.st == M_DONE)) begin
      r.cnt = (lv > MAXV) ? MAXV : lv;
      r.rld = r.cnt;
      r.st = M_IDLE;
    end else if (m.st == M_IDLE) begin
      if (s) r.st = (m.cnt == 0) ? M_DONE : M_RUN;
    end else if (m.st == M_RUN) begin
      if (p) r.st = M_PAUSE;
      else if (e && m.cnt > 0) begin
        r.cnt = m.cnt - 1;
        if (r.cnt == 0) begin
          tk = 1'b1;
          if (ar) r.cnt = m.rld;
          else r.st = M_DONE;
        end
      end
    end else if (m.st == M_PAUSE) begin
      if (!p) r.st = M_RUN;
    end else if (k) begin
      r.st = M_IDLE;
    end
    return r;
  endfunction

  function automatic exp_t to_exp(input mdl_t m, input bit tk);
    exp_t x;
    x.cnt  = 8'(m.cnt);
    x.busy = (m.st == M_RUN) || (m.st == M_PAUSE);
    x.done = (m.st == M_DONE);
    x.tick = tk;
    return x;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue what both instances must show
  task automatic cyc(input bit a, input bit l, input bit s, input bit e, input bit p,
                     input bit k, input int lv);
    bit t0, t1;
    @(negedge clk);
    abort = a; load = l; start = s; en = e; pause = p; ack = k;
    load_val = 8'(lv);
    m0 = nxt(m0, 1'b0, a, l, s, e, p, k, lv, t0);
    m1 = nxt(m1, 1'b1, a, l, s, e, p, k, lv, t1);
    q0.push_back(to_exp(m0, t0));
    q1.push_back(to_exp(m1, t1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every registered update is compared against the oldest queued expectation
  always @(posedge clk) begin
    exp_t e0, e1;
    #1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("count0", int'(count0), int'(e0.cnt));
      chk("busy0", int'(busy0), int'(e0.busy));
      chk("done0", int'(done0), int'(e0.done));
      chk("tick0", int'(tick0), int'(e0.tick));
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("count1", int'(count1), int'(e1.cnt));
      chk("busy1", int'(busy1), int'(e1.busy));
      chk("done1", int'(done1), int'(e1.done));
      chk("tick1", int'(tick1), int'(e1.tick));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_count", int'(count0), 0);
    chk("reset_flags", int'({busy0, done0, tick0, busy1, done1, tick1}), 0);
    rst_n = 1'b1;

    // One-shot countdown from 5, then ack
    cyc(0, 1, 0, 0, 0, 0, 5);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // Gated enable with a 4-cycle pause mid-run
    cyc(0, 1, 0, 0, 0, 0, 3);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, (i % 2) == 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Saturating load, then start from zero
    cyc(0, 1, 0, 0, 0, 0, 250);
    cyc(0, 1, 0, 0, 0, 0, 200);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Reload value 2 and 1 in auto-reload instance
    cyc(0, 1, 0, 0, 0, 0, 2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Abort at 7, load ignored in RUN, load+ack in DONE
    cyc(0, 1, 0, 0, 0, 0, 10);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 50);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 9);
    idle(1);

    // Asynchronous reset between edges mid-run
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    m0 = '{M_IDLE, 0, 0};
    m1 = '{M_IDLE, 0, 0};
    #1;
    chk("async_rst_count", int'(count0) + int'(count1), 0);
    chk("async_rst_flags", int'({busy0, done0, tick0, busy1, done1, tick1}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
          int'($urandom_range(0, 255)));
    end
    idle(2);

    @(posedge clk);
    #2;
    chk("drain", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
